mem_access_unit: RTL and testbench

- Memory-stage load/store unit directly downstream of the address mapper.
- Consumes the M-stage-registered translated address and region enables. Performs byte-lane steering for stores, extraction and sign extension for loads, and misalignment detection.
- Drives the data ROM/RAM port (single-cycle) and a request/acknowledge IO bus port (multi-cycle, stalls the pipeline, with timeout).

---
 rtl/mem_access_unit.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit.
// Steers store bytes onto the data lanes, extracts and extends load data,
// flags misaligned or illegal-size accesses, drives the single-cycle data
// ROM/RAM port directly and runs a small IDLE/REQ/DONE sequencer for the
// multi-cycle request/acknowledge IO bus, stalling the pipeline meanwhile.

`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module mem_access_unit #(
  parameter int XLEN       = `XLEN_64b,
  parameter int IO_TIMEOUT = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_lw_m,
  input  logic                          i_sw_m,
  input  logic [2:0]                    i_funct3_m,
  input  logic [(1<<(XLEN+4))-1:0]      i_addr_m,
  input  logic                          i_data_rom_en_m,
  input  logic                          i_data_ram_en_m,
  input  logic                          i_io_en_m,
  input  logic [(1<<(XLEN+4))-1:0]      i_store_data_m,
  input  logic                          i_flush_m,
  output logic [(1<<(XLEN+4))-1:0]      o_mem_addr,
  output logic                          o_mem_re,
  output logic                          o_mem_we,
  output logic [(1<<(XLEN+4))-1:0]      o_mem_wdata,
  output logic [(1<<(XLEN+4))/8-1:0]    o_mem_wstrb,
  input  logic [(1<<(XLEN+4))-1:0]      i_mem_rdata,
  output logic                          o_io_req,
  output logic                          o_io_we,
  output logic [(1<<(XLEN+4))-1:0]      o_io_addr,
  output logic [(1<<(XLEN+4))-1:0]      o_io_wdata,
  output logic [(1<<(XLEN+4))/8-1:0]    o_io_wstrb,
  input  logic                          i_io_ack,
  input  logic                          i_io_err,
  input  logic [(1<<(XLEN+4))-1:0]      i_io_rdata,
  output logic [(1<<(XLEN+4))-1:0]      o_load_data_m,
  output logic                          o_stall_m,
  output logic                          o_misaligned_load_m,
  output logic                          o_misaligned_store_m,
  output logic                          o_access_fault_m
);

  localparam int DW   = 1 << (XLEN + 4);
  localparam int NB   = DW / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Shift raw lane data down by the byte offset, keep the access size and
  // sign- or zero-extend the result to the full data width.
  function automatic logic [DW-1:0] load_extract_f(input logic [DW-1:0]   raw,
                                                   input logic [OFFW-1:0] off,
                                                   input logic [2:0]      f3);
    logic [DW-1:0] shifted;
    logic [DW-1:0] result;
    logic          sign_bit;
    int            nbits;
    shifted = raw >> {off, 3'b000};
    nbits   = 32'sd8 << f3[1:0];
    case (f3[1:0])
      2'b00:   sign_bit = shifted[7];
      2'b01:   sign_bit = shifted[15];
      2'b10:   sign_bit = shifted[31];
      default: sign_bit = shifted[DW-1];
    endcase
    sign_bit = sign_bit & ~f3[2];
    for (int i = 0; i < DW; i++) begin
      result[i] = (i < nbits) ? shifted[i] : sign_bit;
    end
    return result;
  endfunction

  // Keep the low access-size bytes of the store value and move them up to
  // the addressed lane; unused lanes are driven to zero.
  function automatic logic [DW-1:0] store_steer_f(input logic [DW-1:0]   data,
                                                  input logic [OFFW-1:0] off,
                                                  input logic [1:0]      sz);
    logic [DW-1:0] kept;
    int            nbits;
    nbits = 32'sd8 << sz;
    for (int i = 0; i < DW; i++) begin
      kept[i] = (i < nbits) ? data[i] : 1'b0;
    end
    return kept << {off, 3'b000};
  endfunction

  // Byte strobes: access-size ones shifted to the addressed lane.
  function automatic logic [NB-1:0] strb_f(input logic [OFFW-1:0] off,
                                           input logic [1:0]      sz);
    logic [NB-1:0] base;
    int            nbytes;
    nbytes = 32'sd1 << sz;
    for (int b = 0; b < NB; b++) begin
      base[b] = (b < nbytes);
    end
    return base << off;
  endfunction

  // An access is misaligned when any offset bit below its size is set.
  function automatic logic misaligned_f(input logic [OFFW-1:0] off,
                                        input logic [1:0]      sz);
    logic [OFFW-1:0] low_mask;
    case (sz)
      2'b00:   low_mask = '0;
      2'b01:   low_mask = OFFW'(3'd1);
      2'b10:   low_mask = OFFW'(3'd3);
      default: low_mask = OFFW'(3'd7);
    endcase
    return |(off & low_mask);
  endfunction

  state_t          state_r;
  state_t          next_state_s;
  logic [7:0]      cnt_r;
  logic [DW-1:0]   io_addr_r;
  logic            io_we_r;
  logic [DW-1:0]   io_wdata_r;
  logic [NB-1:0]   io_wstrb_r;
  logic [2:0]      io_funct3_r;
  logic [OFFW-1:0] io_off_r;
  logic [DW-1:0]   io_rdata_r;
  logic            io_err_r;

  logic [OFFW-1:0] off_s;
  logic            legal_s;
  logic            misal_s;
  logic            live_s;
  logic            access_s;
  logic            region_any_s;
  logic            valid_s;
  logic            mem_re_s;
  logic            mem_we_s;
  logic            io_start_s;
  logic            timeout_s;
  logic [DW-1:0]   steer_s;
  logic [NB-1:0]   strb_s;

  assign off_s        = i_addr_m[OFFW-1:0];
  assign misal_s      = misaligned_f(off_s, i_funct3_m[1:0]);
  assign live_s       = ~i_flush_m & ~i_rst;
  assign access_s     = (i_lw_m | i_sw_m) & live_s;
  assign region_any_s = i_data_rom_en_m | i_data_ram_en_m | i_io_en_m;
  assign valid_s      = access_s & ~misal_s & legal_s;
  assign mem_re_s     = valid_s & i_lw_m & (i_data_rom_en_m | i_data_ram_en_m);
  assign mem_we_s     = valid_s & i_sw_m & i_data_ram_en_m;
  assign io_start_s   = valid_s & i_io_en_m;
  assign timeout_s    = (cnt_r == 8'(IO_TIMEOUT - 1));
  assign steer_s      = store_steer_f(i_store_data_m, off_s, i_funct3_m[1:0]);
  assign strb_s       = strb_f(off_s, i_funct3_m[1:0]);

  assign o_mem_addr   = {i_addr_m[DW-1:OFFW], {OFFW{1'b0}}};
  assign o_io_addr    = io_addr_r;
  assign o_io_we      = io_we_r & (state_r == REQ);
  assign o_io_wdata   = io_wdata_r;
  assign o_io_wstrb   = io_wstrb_r;

  // Size legality: no doubleword beyond the data width, no unsigned
  // doubleword load, and stores never carry the unsigned bit.
  always_comb begin
    legal_s = 1'b1;
    if (i_funct3_m == 3'b111) begin
      legal_s = 1'b0;
    end else if (i_sw_m && i_funct3_m[2]) begin
      legal_s = 1'b0;
    end else if ((i_funct3_m[1:0] == 2'b11) && (DW == 32)) begin
      legal_s = 1'b0;
    end else begin
      legal_s = 1'b1;
    end
  end

  // IO sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Capture the IO request on entry and its response (or timeout) on exit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r       <= 8'd0;
      io_addr_r   <= '0;
      io_we_r     <= 1'b0;
      io_wdata_r  <= '0;
      io_wstrb_r  <= '0;
      io_funct3_r <= 3'd0;
      io_off_r    <= '0;
      io_rdata_r  <= '0;
      io_err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (io_start_s) begin
            cnt_r       <= 8'd0;
            io_addr_r   <= o_mem_addr;
            io_we_r     <= i_sw_m;
            io_wdata_r  <= i_sw_m ? steer_s : '0;
            io_wstrb_r  <= i_sw_m ? strb_s : '0;
            io_funct3_r <= i_funct3_m;
            io_off_r    <= off_s;
            io_rdata_r  <= '0;
            io_err_r    <= 1'b0;
          end
        end
        REQ: begin
          if (i_io_ack) begin
            io_rdata_r <= i_io_rdata;
            io_err_r   <= i_io_err;
          end else if (timeout_s) begin
            io_err_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Next state, stall, fault flags and the ROM/RAM port.
  always_comb begin
    next_state_s         = state_r;
    o_mem_re             = 1'b0;
    o_mem_we             = 1'b0;
    o_mem_wdata          = '0;
    o_mem_wstrb          = '0;
    o_io_req             = 1'b0;
    o_stall_m            = 1'b0;
    o_misaligned_load_m  = 1'b0;
    o_misaligned_store_m = 1'b0;
    o_access_fault_m     = 1'b0;
    o_load_data_m        = '0;
    case (state_r)
      IDLE: begin
        o_misaligned_load_m  = i_lw_m & live_s & misal_s;
        o_misaligned_store_m = i_sw_m & live_s & misal_s;
        o_access_fault_m     = access_s & ~legal_s & region_any_s;
        o_mem_re             = mem_re_s;
        o_mem_we             = mem_we_s;
        if (mem_we_s) begin
          o_mem_wdata = steer_s;
          o_mem_wstrb = strb_s;
        end else begin
          o_mem_wdata = '0;
          o_mem_wstrb = '0;
        end
        if (mem_re_s) begin
          o_load_data_m = load_extract_f(i_mem_rdata, off_s, i_funct3_m);
        end else begin
          o_load_data_m = '0;
        end
        if (io_start_s) begin
          o_stall_m    = 1'b1;
          next_state_s = REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        o_io_req  = 1'b1;
        o_stall_m = 1'b1;
        if (i_io_ack || timeout_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = REQ;
        end
      end
      DONE: begin
        o_access_fault_m = io_err_r;
        if (!io_we_r) begin
          o_load_data_m = load_extract_f(io_rdata_r, io_off_r, io_funct3_r);
        end else begin
          o_load_data_m = '0;
        end
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (64-bit data, IO timeout 16).
// The driver computes each access's expected outcome from the access rules
// and queues it; a negedge monitor compares whenever an access completes
// (stall low) and also checks the IO bus fields while a request is open.

module tb_mem_access_unit;

  localparam int DW = 64;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_lw_m = 1'b0, i_sw_m = 1'b0;
  logic [2:0]    i_funct3_m = 3'd0;
  logic [DW-1:0] i_addr_m = '0;
  logic          i_data_rom_en_m = 1'b0, i_data_ram_en_m = 1'b0, i_io_en_m = 1'b0;
  logic [DW-1:0] i_store_data_m = '0;
  logic          i_flush_m = 1'b0;
  logic [DW-1:0] o_mem_addr;
  logic          o_mem_re, o_mem_we;
  logic [DW-1:0] o_mem_wdata;
  logic [7:0]    o_mem_wstrb;
  logic [DW-1:0] i_mem_rdata = '0;
  logic          o_io_req, o_io_we;
  logic [DW-1:0] o_io_addr, o_io_wdata;
  logic [7:0]    o_io_wstrb;
  logic          i_io_ack = 1'b0, i_io_err = 1'b0;
  logic [DW-1:0] i_io_rdata = '0;
  logic [DW-1:0] o_load_data_m;
  logic          o_stall_m, o_misaligned_load_m, o_misaligned_store_m, o_access_fault_m;

  mem_access_unit #(.XLEN(2), .IO_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_lw_m(i_lw_m), .i_sw_m(i_sw_m),
    .i_funct3_m(i_funct3_m), .i_addr_m(i_addr_m),
    .i_data_rom_en_m(i_data_rom_en_m), .i_data_ram_en_m(i_data_ram_en_m),
    .i_io_en_m(i_io_en_m), .i_store_data_m(i_store_data_m), .i_flush_m(i_flush_m),
    .o_mem_addr(o_mem_addr), .o_mem_re(o_mem_re), .o_mem_we(o_mem_we),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb), .i_mem_rdata(i_mem_rdata),
    .o_io_req(o_io_req), .o_io_we(o_io_we), .o_io_addr(o_io_addr),
    .o_io_wdata(o_io_wdata), .o_io_wstrb(o_io_wstrb), .i_io_ack(i_io_ack),
    .i_io_err(i_io_err), .i_io_rdata(i_io_rdata), .o_load_data_m(o_load_data_m),
    .o_stall_m(o_stall_m), .o_misaligned_load_m(o_misaligned_load_m),
    .o_misaligned_store_m(o_misaligned_store_m), .o_access_fault_m(o_access_fault_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          mem_re, mem_we;
    logic [7:0]    wstrb;
    logic [63:0]   wdata;
    logic [63:0]   maddr;
    logic          chk_load;
    logic [63:0]   load;
    logic          mis_ld, mis_st, fault;
    logic          io, io_we;
    int            stall;
  } exp_t;

  exp_t          sb_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic          issue = 1'b0;
  int            io_lat = 0;
  logic [63:0]   io_rd_v = '0;
  logic          io_er_v = 1'b0;
  int            stall_cnt = 0;
  int            req_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Size-limited, extended value of the bytes starting at byte 'off'.
  function automatic logic [63:0] extend(input logic [63:0] raw, input int off,
                                         input int size, input logic uns);
    logic [63:0] mask, v;
    mask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    v = (raw >> (8 * off)) & mask;
    if (!uns && size < 8 && v[8 * size - 1]) v = v | ~mask;
    return v;
  endfunction

  // Reference outcome of one M-stage access.
  function automatic exp_t model(input logic lw, input logic sw, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic rom, input logic ram,
                                 input logic io, input logic [63:0] sdata,
                                 input logic [63:0] mrdata, input logic flush, input int lat,
                                 input logic [63:0] iord, input logic ioer);
    exp_t        e;
    int          size, off;
    logic        active, legal, aligned, valid;
    logic [63:0] mask;
    size    = 1 << f3[1:0];
    off     = int'(addr[2:0]);
    active  = (lw || sw) && !flush;
    legal   = (f3 != 3'd7) && !(sw && f3[2]);
    aligned = (off % size) == 0;
    valid   = active && aligned && legal;
    mask    = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    e.maddr    = addr & ~64'h7;
    e.mis_ld   = lw && !flush && !aligned;
    e.mis_st   = sw && !flush && !aligned;
    e.fault    = active && !legal && (rom || ram || io);
    e.mem_re   = valid && lw && (rom || ram);
    e.mem_we   = valid && sw && ram;
    e.wstrb    = 8'(((1 << size) - 1) << off);
    e.wdata    = (sdata & mask) << (8 * off);
    e.io       = valid && io;
    e.io_we    = sw;
    e.stall    = 0;
    e.chk_load = e.mem_re;
    e.load     = extend(mrdata, off, size, f3[2]);
    if (e.io) begin
      if (lat >= 1 && lat <= TO) begin
        e.stall    = 1 + lat;
        e.fault    = ioer;
        e.chk_load = lw;
        e.load     = extend(iord, off, size, f3[2]);
      end else begin
        e.stall = 1 + TO;
        e.fault = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic issue_op(input logic lw, input logic sw, input logic [2:0] f3,
                          input logic [63:0] addr, input logic rom, input logic ram,
                          input logic io, input logic [63:0] sdata, input logic [63:0] mrdata,
                          input logic flush, input int lat, input logic [63:0] iord,
                          input logic ioer);
    logic done;
    io_lat  = lat;
    io_rd_v = iord;
    io_er_v = ioer;
    i_lw_m = lw; i_sw_m = sw; i_funct3_m = f3; i_addr_m = addr;
    i_data_rom_en_m = rom; i_data_ram_en_m = ram; i_io_en_m = io;
    i_store_data_m = sdata; i_mem_rdata = mrdata; i_flush_m = flush;
    sb_q.push_back(model(lw, sw, f3, addr, rom, ram, io, sdata, mrdata, flush, lat, iord, ioer));
    issue = 1'b1;
    done  = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!o_stall_m) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL stall_bound actual=stuck required=release at %0t", $time);
    end
    @(posedge clk);
    #1;
    issue = 1'b0;
  endtask

  // IO device: acks on the io_lat-th request cycle (never if 0); garbage otherwise.
  always @(posedge clk) begin
    #1;
    if (o_io_req) begin
      req_cyc++;
      i_io_ack   = (io_lat != 0) && (req_cyc == io_lat);
      i_io_rdata = i_io_ack ? io_rd_v : {$urandom, $urandom};
      i_io_err   = i_io_ack ? io_er_v : 1'($urandom);
    end else begin
      req_cyc  = 0;
      i_io_ack = 1'b0;
      i_io_err = 1'b0;
    end
  end

  // Monitor: IO bus fields during requests, full outcome at completion.
  always @(negedge clk) begin
    exp_t e;
    if (issue) begin
      if (o_stall_m) begin
        stall_cnt++;
        if (o_io_req && sb_q.size() > 0) begin
          chk("io_addr", o_io_addr, sb_q[0].maddr);
          chk("io_we", 64'(o_io_we), 64'(sb_q[0].io_we));
          if (sb_q[0].io_we) begin
            chk("io_wstrb", 64'(o_io_wstrb), 64'(sb_q[0].wstrb));
            chk("io_wdata", o_io_wdata, sb_q[0].wdata);
          end
        end
      end else if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_empty actual=completion required=none at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("stall_cycles", 64'(stall_cnt), 64'(e.stall));
        chk("mem_re", 64'(o_mem_re), 64'(e.mem_re));
        chk("mem_we", 64'(o_mem_we), 64'(e.mem_we));
        chk("mis_ld", 64'(o_misaligned_load_m), 64'(e.mis_ld));
        chk("mis_st", 64'(o_misaligned_store_m), 64'(e.mis_st));
        chk("fault", 64'(o_access_fault_m), 64'(e.fault));
        chk("io_req_done", 64'(o_io_req), 64'd0);
        if (e.mem_re || e.mem_we) chk("mem_addr", o_mem_addr, e.maddr);
        if (e.mem_we) begin
          chk("mem_wstrb", 64'(o_mem_wstrb), 64'(e.wstrb));
          chk("mem_wdata", o_mem_wdata, e.wdata);
        end
        if (e.chk_load) chk("load_data", o_load_data_m, e.load);
        stall_cnt = 0;
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_io_req", 64'(o_io_req), 64'd0);
    chk("rst_stall", 64'(o_stall_m), 64'd0);
    chk("rst_load", o_load_data_m, 64'd0);
    chk("rst_fault", 64'(o_access_fault_m), 64'd0);
    chk("rst_mis", 64'({o_misaligned_load_m, o_misaligned_store_m}), 64'd0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;

    // Directed accesses
    issue_op(0, 1, 3'b000, 64'h13, 0, 1, 0, 64'hAB, 64'd0, 0, 0, 64'd0, 0);
    issue_op(1, 0, 3'b001, 64'h6, 0, 1, 0, 64'd0, 64'h8001_0000_0000_0000, 0, 0, 64'd0, 0);
    issue_op(1, 0, 3'b101, 64'h6, 0, 1, 0, 64'd0, 64'h8001_0000_0000_0000, 0, 0, 64'd0, 0);
    issue_op(1, 0, 3'b010, 64'h2, 0, 1, 0, 64'd0, 64'hFFFF, 0, 0, 64'd0, 0);
    issue_op(0, 1, 3'b011, 64'h4, 0, 1, 0, 64'h55, 64'd0, 0, 0, 64'd0, 0);
    issue_op(1, 0, 3'b010, 64'h4, 0, 0, 1, 64'd0, 64'd0, 0, 3, 64'h1234_5678_0000_0000, 0);
    issue_op(0, 1, 3'b010, 64'h8, 0, 0, 1, 64'hCAFE, 64'd0, 0, 0, 64'd0, 0);
    issue_op(1, 0, 3'b011, 64'h18, 0, 0, 1, 64'd0, 64'd0, 0, TO, 64'h0BAD_F00D_1234_5678, 0);
    issue_op(0, 1, 3'b010, 64'h10, 1, 0, 0, 64'h1111, 64'd0, 0, 0, 64'd0, 0);
    issue_op(1, 0, 3'b111, 64'h20, 0, 1, 0, 64'd0, 64'd0, 0, 0, 64'd0, 0);
    issue_op(0, 1, 3'b100, 64'h20, 0, 1, 0, 64'd7, 64'd0, 0, 0, 64'd0, 0);
    issue_op(1, 0, 3'b010, 64'h3, 0, 1, 0, 64'd0, 64'd0, 1, 0, 64'd0, 0);
    issue_op(1, 0, 3'b010, 64'h8, 0, 0, 0, 64'd0, 64'h77, 0, 0, 64'd0, 0);

    // Reset during the second request cycle
    io_lat = 0;
    i_lw_m = 1'b0; i_sw_m = 1'b1; i_funct3_m = 3'b010; i_addr_m = 64'h20;
    i_data_rom_en_m = 1'b0; i_data_ram_en_m = 1'b0; i_io_en_m = 1'b1; i_flush_m = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("req_before_rst", 64'(o_io_req), 64'd1);
    i_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_drop", 64'(o_io_req), 64'd0);
    chk("rst_req_stall", 64'(o_stall_m), 64'd0);
    chk("rst_req_fault", 64'(o_access_fault_m), 64'd0);
    @(posedge clk);
    #1;
    i_sw_m = 1'b0; i_io_en_m = 1'b0;
    i_rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized accesses
    for (int n = 0; n < 400; n++) begin
      logic        lw_v, sw_v, rom_v, ram_v, io_v, fl_v, er_v;
      logic [2:0]  f3_v;
      logic [63:0] a_v;
      int          op, rg, sz, lat_v, lr;
      op = $urandom_range(0, 19);
      lw_v = (op < 9);
      sw_v = (op >= 9) && (op < 18);
      rg = $urandom_range(0, 19);
      rom_v = (rg <= 6);
      ram_v = (rg >= 7) && (rg <= 13);
      io_v  = (rg >= 14) && (rg <= 18);
      f3_v = 3'($urandom_range(0, 7));
      if (sw_v && $urandom_range(0, 3) != 0) f3_v[2] = 1'b0;
      if (rg == 19) begin
        if (sw_v) f3_v[2] = 1'b0;
        if (f3_v == 3'd7) f3_v = 3'd3;
      end
      sz = 1 << f3_v[1:0];
      a_v = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a_v[2:0] = a_v[2:0] & ~3'(sz - 1);
      if (f3_v == 3'd7 || (sw_v && f3_v[2]) || rg == 19) a_v[2:0] = 3'd0;
      fl_v = ($urandom_range(0, 9) == 0);
      lr = $urandom_range(0, 9);
      lat_v = (lr == 0) ? 0 : (lr == 1) ? TO : $urandom_range(1, 5);
      er_v = ($urandom_range(0, 4) == 0);
      issue_op(lw_v, sw_v, f3_v, a_v, rom_v, ram_v, io_v, {$urandom, $urandom},
               {$urandom, $urandom}, fl_v, lat_v, {$urandom, $urandom}, er_v);
    end

    repeat (3) @(posedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
